// File: rtl/fft_bitreverse.sv
// fft_bitreverse: natural-order reordering stage behind a pipelined FFT.
// The FFT emits each frame in bit-reversed bin order. Frames are written in
// arrival order into one half of a ping-pong RAM. The other half, which holds
// the previous complete frame, is read back at bit-reversed addresses, so bins
// leave in natural order (bin 0 first).
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset_n  synchronous active-low reset
//   i_ce       clock enable; one sample in and one out per enabled cycle
//   i_in       bit-reversed-order sample (WIDTH bits, passed through untouched)
//   i_sync     marks bit-reversed index 0 of a frame on i_in
//   o_out      natural-order sample (registered)
//   o_sync     high with natural bin 0 of each output frame (registered)
module fft_bitreverse #(
  parameter int unsigned LGSIZE = 10,
  parameter int unsigned WIDTH  = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_sync,
  output logic [WIDTH-1:0] o_out,
  output logic             o_sync
);

  localparam int unsigned N = 1 << LGSIZE;

  // Memory contents are never reset; full_q gates every read instead.
  logic [WIDTH-1:0] mem_q [2*N];

  logic              started_q, started_d;
  logic              full_q, full_d;
  logic              wbank_q, wbank_d;
  logic [LGSIZE-1:0] widx_q, widx_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              sync_q, sync_d;

  logic              active;
  logic              resync;
  logic              wr_en;
  logic [LGSIZE:0]   wr_addr;
  logic [LGSIZE:0]   rd_addr;
  logic [LGSIZE-1:0] widx_rev;

  // Bit reversal is pure wiring.
  for (genvar k = 0; k < LGSIZE; k++) begin : g_rev
    assign widx_rev[k] = widx_q[LGSIZE-1-k];
  end

  // Read uses the pre-increment index in the bank not being written.
  assign rd_addr = {~wbank_q, widx_rev};

  always_comb begin
    started_d = started_q;
    full_d    = full_q;
    wbank_d   = wbank_q;
    widx_d    = widx_q;
    out_d     = out_q;
    sync_d    = sync_q;
    wr_en     = 1'b0;
    wr_addr   = {wbank_q, widx_q};

    active = started_q | i_sync;
    // A frame start arriving mid-frame restarts framing in the other bank and
    // throws away the partial frame along with the one queued for output.
    resync = i_sync & started_q & (widx_q != '0);

    if (i_ce) begin
      out_d  = full_q ? mem_q[rd_addr] : '0;
      sync_d = full_q & (widx_q == '0) & active;

      if (resync) begin
        wr_en   = 1'b1;
        wr_addr = {~wbank_q, {LGSIZE{1'b0}}};
        wbank_d = ~wbank_q;
        widx_d  = LGSIZE'(1);
        full_d  = 1'b0;
        out_d   = '0;
        sync_d  = 1'b0;
      end else if (active) begin
        wr_en     = 1'b1;
        started_d = 1'b1;
        widx_d    = widx_q + LGSIZE'(1);
        if (&widx_q) begin
          wbank_d = ~wbank_q;
          full_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      started_q <= 1'b0;
      full_q    <= 1'b0;
      wbank_q   <= 1'b0;
      widx_q    <= '0;
      out_q     <= '0;
      sync_q    <= 1'b0;
    end else begin
      started_q <= started_d;
      full_q    <= full_d;
      wbank_q   <= wbank_d;
      widx_q    <= widx_d;
      out_q     <= out_d;
      sync_q    <= sync_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n && wr_en) begin
      mem_q[wr_addr] <= i_in;
    end
  end

  assign o_out  = out_q;
  assign o_sync = sync_q;

endmodule

// File: tb/tb_fft_bitreverse.sv
module tb_fft_bitreverse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: N = 8
  logic        rst_n, ce, sync;
  logic [31:0] din;
  logic [31:0] dout;
  logic        dsync;

  // Large instance: N = 1024
  logic        rst_n_b, ce_b, sync_b;
  logic [31:0] din_b;
  logic [31:0] dout_b;
  logic        dsync_b;

  fft_bitreverse #(.LGSIZE(3), .WIDTH(32)) u_small (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_ce      (ce),
    .i_in      (din),
    .i_sync    (sync),
    .o_out     (dout),
    .o_sync    (dsync)
  );

  fft_bitreverse #(.LGSIZE(10), .WIDTH(32)) u_big (
    .i_clk     (clk),
    .i_reset_n (rst_n_b),
    .i_ce      (ce_b),
    .i_in      (din_b),
    .i_sync    (sync_b),
    .o_out     (dout_b),
    .o_sync    (dsync_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-computed 3-bit reversal: rev3[m] = bitrev(m)
  int rev3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic [31:0] big_in [5*1024];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [31:0] d, input logic e);
    sync = s;
    din  = d;
    ce   = e;
    tick();
  endtask

  task automatic expect_out(input string tag, input logic [31:0] eo, input logic es);
    check({tag, ".out"}, dout, eo);
    check({tag, ".sync"}, {31'd0, dsync}, {31'd0, es});
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    // Enabled, synced input during reset must have no effect.
    sync = 1'b1;
    din  = 32'hFFFF_FFFF;
    ce   = 1'b1;
    tick();
    tick();
    expect_out({tag, ".rst"}, 32'd0, 1'b0);
    rst_n = 1'b1;
    sync  = 1'b0;
  endtask

  // Feed nframes aligned frames whose element i of frame f is base+8f+i.
  // Expected output for frame f-1 position m is base+8(f-1)+rev3[m].
  task automatic run_frames(input string tag, input int nframes, input int base, input bit gap);
    for (int k = 0; k < nframes * 8; k++) begin
      int m;
      logic [31:0] eo;
      logic es;
      m = k % 8;
      if (k < 8) begin
        eo = 32'd0;
        es = 1'b0;
      end else begin
        eo = 32'(base + (k / 8 - 1) * 8 + rev3[m]);
        es = (m == 0);
      end
      drive(m == 0, 32'(base + k), 1'b1);
      expect_out(tag, eo, es);
      if (gap) begin
        // Disabled cycle with junk and a sync: everything must hold.
        drive(1'b1, 32'h0000_0BAD, 1'b0);
        expect_out({tag, ".hold"}, eo, es);
      end
    end
  endtask

  function automatic int bitrev10(input int x);
    int r;
    r = 0;
    for (int b = 0; b < 10; b++) begin
      if (((x >> b) & 1) != 0) r |= 1 << (9 - b);
    end
    return r;
  endfunction

  initial begin
    rst_n   = 1'b0;
    ce      = 1'b0;
    sync    = 1'b0;
    din     = '0;
    rst_n_b = 1'b0;
    ce_b    = 1'b0;
    sync_b  = 1'b0;
    din_b   = '0;

    // 1: two aligned frames plus a flushing third
    do_reset("s1");
    run_frames("s1", 3, 0, 1'b0);

    // 2: junk before the first sync is dropped
    do_reset("s2");
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0000_DEAD, 1'b1);
      expect_out("s2.junk", 32'd0, 1'b0);
    end
    run_frames("s2", 3, 0, 1'b0);

    // 3: clock enable toggling every cycle
    do_reset("s3");
    run_frames("s3", 3, 0, 1'b1);

    // 4: spurious sync at widx=5 of frame B
    do_reset("s4");
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 32'(i), 1'b1);
      expect_out("s4.a", 32'd0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, 32'(8 + i), 1'b1);
      expect_out("s4.b", 32'(rev3[i]), i == 0);
    end
    drive(1'b1, 32'd100, 1'b1);
    expect_out("s4.resync", 32'd0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 32'(100 + i), 1'b1);
      expect_out("s4.r", 32'd0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 32'(200 + i), 1'b1);
      expect_out("s4.rout", 32'(100 + rev3[i]), i == 0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 32'(300 + i), 1'b1);
      expect_out("s4.sout", 32'(200 + rev3[i]), i == 0);
    end

    // 5: one-cycle reset at widx=3 of frame B
    do_reset("s5");
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 32'(i), 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 32'(8 + i), 1'b1);
      expect_out("s5.b", 32'(rev3[i]), i == 0);
    end
    rst_n = 1'b0;
    drive(1'b0, 32'd11, 1'b1);
    expect_out("s5.midrst", 32'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'(500 + i), 1'b1);
      expect_out("s5.nosync", 32'd0, 1'b0);
    end
    run_frames("s5", 2, 40, 1'b0);
    ce = 1'b0;

    // 6: N=1024, random data, four checked frames plus a flushing fifth
    for (int k = 0; k < 5 * 1024; k++) big_in[k] = $urandom();
    rst_n_b = 1'b0;
    ce_b    = 1'b1;
    tick();
    tick();
    check("s6.rst.out", dout_b, 32'd0);
    rst_n_b = 1'b1;
    begin
      int last_sync;
      int n_sync;
      last_sync = -1;
      n_sync    = 0;
      for (int k = 0; k < 5 * 1024; k++) begin
        int m;
        int f;
        sync_b = (k % 1024 == 0);
        din_b  = big_in[k];
        tick();
        m = k % 1024;
        f = k / 1024 - 1;
        if (k < 1024) begin
          check("s6.first.out", dout_b, 32'd0);
          check("s6.first.sync", {31'd0, dsync_b}, 32'd0);
        end else begin
          check("s6.out", dout_b, big_in[f * 1024 + bitrev10(m)]);
          check("s6.sync", {31'd0, dsync_b}, {31'd0, m == 0});
        end
        if (dsync_b) begin
          if (last_sync >= 0) check("s6.period", 32'(k - last_sync), 32'd1024);
          last_sync = k;
          n_sync++;
        end
      end
      check("s6.nsync", 32'(n_sync), 32'd4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
